// File: rtl/wind_pkg.sv
// Shared widths, types and the speed saturation helper for the wind-speed estimator.
package wind_pkg;
  localparam int SAMPLE_W  = 12;
  localparam int FRAC_BITS = 4;
  localparam int IDX_W     = 12;
  localparam int TIME_W    = IDX_W + FRAC_BITS;
  localparam int SPEED_W   = 16;
  localparam int PROD_W    = 25;
  localparam int DIV_W     = SAMPLE_W + 1 + FRAC_BITS;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [TIME_W-1:0]   time_t;
  typedef logic signed [SPEED_W-1:0]  speed_t;

  typedef enum logic [0:0] {DIV_IDLE, DIV_RUN}  div_state_t;
  typedef enum logic [0:0] {VAL_IDLE, VAL_WAIT} val_state_t;

  function automatic speed_t saturate(input logic signed [PROD_W-1:0] v);
    localparam logic signed [PROD_W-1:0] SMAX = 25'sd32767;
    localparam logic signed [PROD_W-1:0] SMIN = -25'sd32768;
    speed_t r;
    if (v > SMAX)      r = 16'sh7fff;
    else if (v < SMIN) r = 16'sh8000;
    else               r = v[SPEED_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/wind_speed_est_arrival_detector.sv
// Per-channel burst arrival detector: threshold arming, first rising zero crossing,
// and a 5-step restoring divider producing the 1/16-sample interpolated arrival time.
module arrival_detector
  import wind_pkg::*;
#(
  parameter int unsigned THRESH = 200
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_first,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic                       o_found,
  output logic [TIME_W-1:0]          o_time
);
  logic signed [SAMPLE_W-1:0] r_prev;
  logic                       r_armed;
  logic                       r_found;
  div_state_t                 r_state;
  div_state_t                 w_state_nxt;
  logic [DIV_W-1:0]           r_rem;
  logic [DIV_W-1:0]           r_dsh;
  logic [4:0]                 r_q;
  logic [2:0]                 r_step;
  logic [IDX_W-1:0]           r_idx;
  logic [TIME_W-1:0]          r_time;

  logic [SAMPLE_W-1:0] w_prev;
  logic                w_armed;
  logic                w_found;
  logic [SAMPLE_W:0]   w_ext_cur;
  logic [SAMPLE_W:0]   w_ext_prev;
  logic [SAMPLE_W:0]   w_mag;
  logic [SAMPLE_W:0]   w_den;
  logic [SAMPLE_W:0]   w_negp;
  logic                w_hit;
  logic                w_cross;
  logic [DIV_W:0]      w_trial;
  logic                w_ok;
  logic [4:0]          w_q_nxt;
  logic [IDX_W-1:0]    w_idx_m1;

  // Frame start: previous sample, arming and found state read as cleared.
  assign w_prev     = i_first ? '0 : r_prev;
  assign w_armed    = i_first ? 1'b0 : r_armed;
  assign w_found    = i_first ? 1'b0 : r_found;
  assign w_ext_cur  = {i_sample[SAMPLE_W-1], i_sample};
  assign w_ext_prev = {w_prev[SAMPLE_W-1], w_prev};
  assign w_mag      = w_ext_cur[SAMPLE_W] ? ('0 - w_ext_cur) : w_ext_cur;
  assign w_hit      = (w_mag >= (SAMPLE_W+1)'(THRESH));
  assign w_cross    = w_armed & ~w_found & w_prev[SAMPLE_W-1] & ~i_sample[SAMPLE_W-1];
  assign w_den      = w_ext_cur - w_ext_prev;
  assign w_negp     = '0 - w_ext_prev;

  assign w_trial  = {1'b0, r_rem} - {1'b0, r_dsh};
  assign w_ok     = ~w_trial[DIV_W];
  assign w_q_nxt  = {r_q[3:0], w_ok};
  assign w_idx_m1 = r_idx - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (i_en && w_cross) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (r_step == 3'd4)  w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev  <= '0;
      r_armed <= 1'b0;
      r_found <= 1'b0;
      r_state <= DIV_IDLE;
      r_rem   <= '0;
      r_dsh   <= '0;
      r_q     <= '0;
      r_step  <= '0;
      r_idx   <= '0;
      r_time  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_en) begin
        r_prev  <= i_sample;
        r_armed <= w_armed | w_hit;
        r_found <= w_found | w_cross;
        if (w_cross) begin
          r_rem  <= {w_negp, {FRAC_BITS{1'b0}}};
          r_dsh  <= {w_den, {FRAC_BITS{1'b0}}};
          r_q    <= '0;
          r_step <= '0;
          r_idx  <= i_idx;
        end
      end else if (r_state == DIV_RUN) begin
        // Divisor starts pre-shifted by 4 and walks right: one quotient bit per clock.
        if (w_ok) r_rem <= w_trial[DIV_W-1:0];
        r_q    <= w_q_nxt;
        r_dsh  <= r_dsh >> 1;
        r_step <= r_step + 1'b1;
        if (r_step == 3'd4)
          r_time <= {w_idx_m1, {FRAC_BITS{1'b0}}} + TIME_W'(w_q_nxt);
      end
    end
  end

  assign o_found = r_found;
  assign o_time  = r_time;
endmodule

// File: rtl/wind_speed_est.sv
// Wind-speed estimator top: frame counter, two arrival detectors, scaled saturated
// arrival-time difference with a valid strobe 8 clocks after the frame's last sample.
module wind_speed_est
  import wind_pkg::*;
#(
  parameter int unsigned       FRAME_LEN = 1000,
  parameter int unsigned       THRESH    = 200,
  parameter logic signed [7:0] GAIN      = 8'sd1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       endata,
  input  logic signed [SAMPLE_W-1:0] rx1,
  input  logic signed [SAMPLE_W-1:0] rx2,
  output logic signed [SPEED_W-1:0]  speed,
  output logic                       validOutput
);
  logic [IDX_W-1:0]          r_idx;
  val_state_t                r_vstate;
  val_state_t                w_vstate_nxt;
  logic [3:0]                r_cnt;
  logic signed [SPEED_W-1:0] r_speed;
  logic                      r_valid;

  logic                      w_last;
  logic                      w_first;
  logic                      w_fire;
  logic                      w_found1;
  logic                      w_found2;
  logic [TIME_W-1:0]         w_t1;
  logic [TIME_W-1:0]         w_t2;
  logic signed [TIME_W:0]    w_diff;
  logic signed [PROD_W-1:0]  w_prod;

  assign w_last  = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign w_first = (r_idx == '0);

  arrival_detector #(.THRESH(THRESH)) u_det1 (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_en     (endata),
    .i_first  (w_first),
    .i_idx    (r_idx),
    .i_sample (rx1),
    .o_found  (w_found1),
    .o_time   (w_t1)
  );

  arrival_detector #(.THRESH(THRESH)) u_det2 (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_en     (endata),
    .i_first  (w_first),
    .i_idx    (r_idx),
    .i_sample (rx2),
    .o_found  (w_found2),
    .o_time   (w_t2)
  );

  assign w_diff = $signed({1'b0, w_t1}) - $signed({1'b0, w_t2});
  assign w_prod = PROD_W'(w_diff) * PROD_W'(GAIN);

  // Count 0..7 after the last-sample edge; firing on count 7 lands on edge +8.
  always_comb begin
    w_vstate_nxt = r_vstate;
    w_fire       = 1'b0;
    case (r_vstate)
      VAL_IDLE: if (endata && w_last) w_vstate_nxt = VAL_WAIT;
      VAL_WAIT: if (r_cnt == 4'd7) begin
        w_vstate_nxt = VAL_IDLE;
        w_fire       = 1'b1;
      end
      default:  w_vstate_nxt = VAL_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx    <= '0;
      r_vstate <= VAL_IDLE;
      r_cnt    <= '0;
      r_speed  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (endata) r_idx <= w_last ? '0 : r_idx + 1'b1;
      r_vstate <= w_vstate_nxt;
      r_cnt    <= (r_vstate == VAL_WAIT) ? r_cnt + 1'b1 : '0;
      r_valid  <= w_fire & w_found1 & w_found2;
      if (w_fire && w_found1 && w_found2) r_speed <= saturate(w_prod);
    end
  end

  assign speed       = r_speed;
  assign validOutput = r_valid;
endmodule

// File: tb/tb_wind_speed_est.sv
// Self-checking bench: frame table driven through gain-1 and gain-127 instances,
// results checked by a scoreboard keyed on the expected valid edge.
module tb_wind_speed_est;
  localparam int FL = 1000;

  logic              clock = 1'b0;
  logic              reset;
  logic              endata;
  logic signed [11:0] rx1, rx2;
  logic signed [15:0] speed, speed_g;
  logic              valid, valid_g;

  always #5 clock = ~clock;

  wind_speed_est #(.FRAME_LEN(FL), .THRESH(200), .GAIN(8'sd1)) dut (
    .clock(clock), .reset(reset), .endata(endata), .rx1(rx1), .rx2(rx2),
    .speed(speed), .validOutput(valid));

  wind_speed_est #(.FRAME_LEN(FL), .THRESH(200), .GAIN(8'sd127)) dut_g (
    .clock(clock), .reset(reset), .endata(endata), .rx1(rx1), .rx2(rx2),
    .speed(speed_g), .validOutput(valid_g));

  // kind: 0 silent, 1 burst starting at pos, 2 arm_val/p/q at pos-2/pos-1/pos
  typedef struct { int kind; int pos; int arm_val; int p; int q; } chan_t;
  typedef struct { chan_t c1; chan_t c2; bit vld; int exp1; int expg; string name; } vec_t;
  typedef struct { int at_edge; int exp1; int expg; string name; } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  vec_t vecs[7];
  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int last1 = 0;
  int lastg = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0 && edge_cnt == sb[0].at_edge) begin
      mon_e = sb.pop_front();
      check({mon_e.name, " valid"}, int'(valid), 1);
      check({mon_e.name, " valid gain127"}, int'(valid_g), 1);
      check({mon_e.name, " speed"}, int'(speed), mon_e.exp1);
      check({mon_e.name, " speed gain127"}, int'(speed_g), mon_e.expg);
    end else if (valid || valid_g) begin
      check("unexpected validOutput", int'(valid) + int'(valid_g), 0);
    end
  end

  function automatic int wave(input chan_t c, input int n);
    int k;
    if (c.kind == 1 && n >= c.pos && n < c.pos + 40) begin
      k = (n - c.pos) % 8;
      case (k)
        0, 4:    return 0;
        1, 3:    return 707;
        2:       return 1000;
        5, 7:    return -707;
        default: return -1000;
      endcase
    end
    if (c.kind == 2) begin
      if (n == c.pos - 2) return c.arm_val;
      if (n == c.pos - 1) return c.p;
      if (n == c.pos)     return c.q;
    end
    return 0;
  endfunction

  task automatic put_sample(input int a, input int b, output int e);
    @(negedge clock);
    endata = 1'b1;
    rx1 = 12'(a);
    rx2 = 12'(b);
    @(negedge clock);
    endata = 1'b0;
    e = edge_cnt;
    repeat (6) @(negedge clock);
  endtask

  task automatic run_frame(input vec_t v, input int nsamp);
    int e;
    for (int n = 0; n < nsamp; n++) begin
      put_sample(wave(v.c1, n), wave(v.c2, n), e);
      if (n == FL - 1 && v.vld) sb.push_back('{e + 8, v.exp1, v.expg, v.name});
    end
  endtask

  initial begin
    reset = 1'b1;
    endata = 1'b0;
    rx1 = '0;
    rx2 = '0;

    vecs[0] = '{'{1, 100, 0, 0, 0}, '{1, 100, 0, 0, 0}, 1'b1, 0, 0, "identical bursts"};
    vecs[1] = '{'{1, 100, 0, 0, 0}, '{1, 102, 0, 0, 0}, 1'b1, -32, -4064, "rx2 delayed 2"};
    vecs[2] = '{'{2, 51, 1000, -100, 300}, '{2, 51, -2048, -300, 100}, 1'b1, -8, -1016, "interpolation"};
    vecs[3] = '{'{2, 151, 1000, -100, 300}, '{2, 101, 1000, -100, 300}, 1'b1, 800, 32767, "sat positive"};
    vecs[4] = '{'{2, 101, 1000, -100, 300}, '{2, 151, 1000, -100, 300}, 1'b1, -800, -32768, "sat negative"};
    vecs[5] = '{'{1, 100, 0, 0, 0}, '{0, 0, 0, 0, 0}, 1'b0, 0, 0, "rx2 silent"};
    vecs[6] = '{'{2, 999, 1000, -100, 300}, '{2, 998, 1000, -100, 300}, 1'b1, 16, 2032, "last-sample crossing"};

    repeat (3) @(negedge clock);
    check("reset speed", int'(speed), 0);
    check("reset valid", int'(valid), 0);
    check("reset speed gain127", int'(speed_g), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], FL);
      if (vecs[i].vld) begin
        last1 = vecs[i].exp1;
        lastg = vecs[i].expg;
      end else begin
        repeat (4) @(negedge clock);
        check({vecs[i].name, " speed held"}, int'(speed), last1);
        check({vecs[i].name, " speed held gain127"}, int'(speed_g), lastg);
      end
    end

    // Partial frame, then a 2-clock reset, then a full frame from index 0.
    run_frame(vecs[1], 300);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("mid-frame reset speed", int'(speed), 0);
    check("mid-frame reset speed gain127", int'(speed_g), 0);
    check("mid-frame reset valid", int'(valid), 0);
    reset = 1'b0;
    run_frame(vecs[1], FL);
    repeat (12) @(negedge clock);
    check("results outstanding", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
